dt_coeff_gen: RTL
=================

DT_COEFF_GEN -- requirements
Module: dt_coeff_gen

Interface
REQ-001 SHALL have parameter DBL_WIDTH, default 64, meaning IEEE-754 double operand width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to compute coefficients.
REQ-005 SHALL have port delta_t  input  DBL_WIDTH  time step (double), sampled on accepted start.
REQ-006 SHALL have port busy  output  1  high from accepted start until valid_out cycle inclusive.
REQ-007 SHALL have port delta_t_out  output  DBL_WIDTH  captured delta_t.
REQ-008 SHALL have ports dt2_half, dt3_sixth, dt4_twelth, dt5_twelth, dt6_thirtysix  output  DBL_WIDTH each  dt^2/2, dt^3/6, dt^4/12, dt^5/12, dt^6/36.
REQ-009 SHALL have port valid_out  output  1  one-cycle pulse: all six outputs updated.

Function
REQ-010 SHALL accept start only in S_IDLE; start while busy SHALL be ignored, with no effect on state or outputs.
REQ-011 SHALL instantiate two fp_multiplier units (mul0, mul1), each with the valid/ready/finish/a/b/result protocol; valid SHALL be a one-cycle pulse asserted only when that unit's ready is high.
REQ-012 SHALL capture each unit's result on its finish pulse into a sticky per-unit done flag, and SHALL advance a round only when all units issued in that round are done; finishes in different cycles SHALL both be accepted.
REQ-013 SHALL use FSM states S_IDLE, S_P2, S_P34, S_P56, S_S12, S_S34, S_S6, S_DONE, in that order.
REQ-014 S_P2: mul0 = dt*dt -> p2.
REQ-015 S_P34: mul0 = p2*dt -> p3; mul1 = p2*p2 -> p4.
REQ-016 S_P56: mul0 = p3*p2 -> p5; mul1 = p3*p3 -> p6.
REQ-017 S_S12: mul0 = p2*C_HALF; mul1 = p3*C_SIXTH.
REQ-018 S_S34: mul0 = p4*C_TWELFTH; mul1 = p5*C_TWELFTH.
REQ-019 S_S6: mul0 = p6*C_THIRTYSIXTH.
REQ-020 Constants SHALL be C_HALF=0x3FE0000000000000, C_SIXTH=0x3FC5555555555555, C_TWELFTH=0x3FB5555555555555, C_THIRTYSIXTH=0x3F9C71C71C71C71C.
REQ-021 Each round's go SHALL be issued on the edge after the previous round completes (ready permitting); if ready is low, the FSM SHALL wait in place with operands held.
REQ-022 S_DONE SHALL update all six outputs in the same edge, pulse valid_out for exactly one cycle, and return to S_IDLE; busy SHALL drop the following cycle.
REQ-023 Outputs SHALL hold their last values between completions; no partial update SHALL be visible.
REQ-024 Latency from start to valid_out SHALL equal the sum of six multiplier round latencies plus at most 2 cycles per round plus 1.
REQ-025 Results SHALL be bit-exact to the fp_multiplier chain above; no special handling of NaN/Inf/denormal beyond the multiplier's own.

Reset
REQ-026 On rst_n low, asynchronously: state=S_IDLE; busy=0; valid_out=0; all go pulses=0; done flags=0; p2..p6 and all DBL_WIDTH outputs=0.
REQ-027 Reset asserted mid-computation SHALL abort the run; after release the block SHALL be idle and SHALL produce no valid_out until a new start.

Structure
REQ-028 The four coefficient constants and the state enum SHALL live in the shared Kalman package; the multiplier SHALL be the existing fp_multiplier, with no new sub-module.

Verification
REQ-029 delta_t=0x3FF0000000000000 (1.0) -> dt2_half=0x3FE0000000000000, dt3_sixth=0x3FC5555555555555, dt4_twelth=dt5_twelth=0x3FB5555555555555, dt6_thirtysix=0x3F9C71C71C71C71C, one valid_out.
REQ-030 delta_t=0x4000000000000000 (2.0) -> dt2_half=0x4000000000000000, dt3_sixth=dt4_twelth=0x3FF5555555555555, dt5_twelth=0x4005555555555555, dt6_thirtysix=0x3FFC71C71C71C71C.
REQ-031 delta_t=0 -> all coefficient outputs 0, delta_t_out=0, valid_out once.
REQ-032 Run with dt=1.0, then start with dt=2.0 pulsed while busy -> ignored; single valid_out with dt=1.0 results; outputs hold afterwards.
REQ-033 rst_n low midway through S_P56 -> outputs 0, busy 0 immediately; no valid_out; a fresh start with 2.0 then yields the REQ-030 values.
REQ-034 Multiplier model with unequal finish delays (mul1 finishes 3 cycles after mul0) -> correct values, no lost result, no hang.

Source files
------------

// File: rtl/dt_coeff_gen_pkg.sv
// Shared Kalman package: coefficient constants, coefficient FSM states and a
// double-precision multiply helper used by fp_multiplier.
package dt_coeff_gen_pkg;

  localparam logic [63:0] C_HALF        = 64'h3FE0000000000000;
  localparam logic [63:0] C_SIXTH       = 64'h3FC5555555555555;
  localparam logic [63:0] C_TWELFTH     = 64'h3FB5555555555555;
  localparam logic [63:0] C_THIRTYSIXTH = 64'h3F9C71C71C71C71C;
  localparam logic [63:0] C_QNAN        = 64'h7FF8000000000000;

  typedef enum logic [2:0] {
    S_IDLE, S_P2, S_P34, S_P56, S_S12, S_S34, S_S6, S_DONE
  } state_e;

  // Round-to-nearest-even; subnormal operands and underflowing results flush to signed zero.
  function automatic logic [63:0] fp_mul64(input logic [63:0] a, input logic [63:0] b);
    logic               s;
    logic [10:0]        ea, eb;
    logic [105:0]       prod;
    logic [51:0]        man;
    logic               g, st;
    logic [52:0]        rnd;
    logic signed [13:0] e;
    logic               nan_a, nan_b;
    logic [63:0]        r;
    s     = a[63] ^ b[63];
    ea    = a[62:52];
    eb    = b[62:52];
    nan_a = (ea == 11'h7FF) && (a[51:0] != 52'h0);
    nan_b = (eb == 11'h7FF) && (b[51:0] != 52'h0);
    prod  = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
    if (prod[105]) begin
      man = prod[104:53];
      g   = prod[52];
      st  = |prod[51:0];
    end else begin
      man = prod[103:52];
      g   = prod[51];
      st  = |prod[50:0];
    end
    e   = $signed(14'(ea) + 14'(eb) + 14'(prod[105])) - 14'sd1023;
    rnd = {1'b0, man} + 53'(g & (st | man[0]));
    if (rnd[52]) e = e + 14'sd1;
    if (nan_a || nan_b || (ea == 11'h7FF && eb == 11'h0) || (eb == 11'h7FF && ea == 11'h0))
      r = C_QNAN;
    else if (ea == 11'h7FF || eb == 11'h7FF)
      r = {s, 11'h7FF, 52'h0};
    else if (ea == 11'h0 || eb == 11'h0 || e <= 14'sd0)
      r = {s, 63'h0};
    else if (e >= 14'sd2047)
      r = {s, 11'h7FF, 52'h0};
    else
      r = {s, e[10:0], rnd[51:0]};
    return r;
  endfunction

endpackage

// File: rtl/fp_multiplier.sv
// Double-precision multiplier with valid/ready/finish handshake: one operation in
// flight, finish pulses LATENCY cycles after the accepting edge, result holds until the next accept.
module fp_multiplier
  import dt_coeff_gen_pkg::*;
#(
  parameter int DBL_WIDTH = 64,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  output logic                 ready,
  output logic                 finish,
  input  logic [DBL_WIDTH-1:0] a,
  input  logic [DBL_WIDTH-1:0] b,
  output logic [DBL_WIDTH-1:0] result
);
  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d, fin_q, fin_d;
  logic [DBL_WIDTH-1:0] res_q, res_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    fin_d  = 1'b0;
    res_d  = res_q;
    if (valid && !busy_q) begin
      res_d  = DBL_WIDTH'(fp_mul64(64'(a), 64'(b)));
      cnt_d  = CW'(LATENCY);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        fin_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      fin_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      fin_q  <= fin_d;
      res_q  <= res_d;
    end
  end

  assign ready  = !busy_q;
  assign finish = fin_q;
  assign result = res_q;
endmodule

// File: rtl/dt_coeff_gen.sv
// Computes dt^2/2, dt^3/6, dt^4/12, dt^5/12, dt^6/36 with two shared multipliers in six rounds.
// IDLE wait start | P2 dt^2 | P34 dt^3,dt^4 | P56 dt^5,dt^6 | S12/S34/S6 scale powers in place | DONE publish
module dt_coeff_gen
  import dt_coeff_gen_pkg::*;
#(
  parameter int DBL_WIDTH    = 64,
  parameter int MUL0_LATENCY = 2,
  parameter int MUL1_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DBL_WIDTH-1:0] delta_t,
  output logic                 busy,
  output logic [DBL_WIDTH-1:0] delta_t_out,
  output logic [DBL_WIDTH-1:0] dt2_half,
  output logic [DBL_WIDTH-1:0] dt3_sixth,
  output logic [DBL_WIDTH-1:0] dt4_twelth,
  output logic [DBL_WIDTH-1:0] dt5_twelth,
  output logic [DBL_WIDTH-1:0] dt6_thirtysix,
  output logic                 valid_out
);
  localparam int W = DBL_WIDTH;

  state_e       state_q, state_d;
  logic         issued_q, issued_d, done0_q, done0_d, done1_q, done1_d, valid_q, valid_d;
  logic [W-1:0] dt_q, dt_d, r0_q, r0_d, r1_q, r1_d;
  logic [W-1:0] p2_q, p2_d, p3_q, p3_d, p4_q, p4_d, p5_q, p5_d, p6_q, p6_d;
  logic [W-1:0] odt_q, odt_d, o2_q, o2_d, o3_q, o3_d, o4_q, o4_d, o5_q, o5_d, o6_q, o6_d;
  logic         need0, need1, issue, round_done, rdy0, rdy1, fin0, fin1;
  logic [W-1:0] a0, b0, a1, b1, m0_res, m1_res, res0, res1;

  fp_multiplier #(.DBL_WIDTH(W), .LATENCY(MUL0_LATENCY)) mul0 (
    .clk(clk), .rst_n(rst_n), .valid(issue), .ready(rdy0), .finish(fin0),
    .a(a0), .b(b0), .result(m0_res)
  );
  fp_multiplier #(.DBL_WIDTH(W), .LATENCY(MUL1_LATENCY)) mul1 (
    .clk(clk), .rst_n(rst_n), .valid(issue && need1), .ready(rdy1), .finish(fin1),
    .a(a1), .b(b1), .result(m1_res)
  );

  assign need0      = state_q inside {S_P2, S_P34, S_P56, S_S12, S_S34, S_S6};
  assign need1      = state_q inside {S_P34, S_P56, S_S12, S_S34};
  assign issue      = need0 && !issued_q && rdy0 && (rdy1 || !need1);
  assign res0       = done0_q ? r0_q : m0_res;
  assign res1       = done1_q ? r1_q : m1_res;
  assign round_done = issued_q && (done0_q || fin0) && (!need1 || done1_q || fin1);

  always_comb begin
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    case (state_q)
      S_P2:  begin a0 = dt_q; b0 = dt_q; end
      S_P34: begin a0 = p2_q; b0 = dt_q; a1 = p2_q; b1 = p2_q; end
      S_P56: begin a0 = p3_q; b0 = p2_q; a1 = p3_q; b1 = p3_q; end
      S_S12: begin a0 = p2_q; b0 = W'(C_HALF); a1 = p3_q; b1 = W'(C_SIXTH); end
      S_S34: begin a0 = p4_q; b0 = W'(C_TWELFTH); a1 = p5_q; b1 = W'(C_TWELFTH); end
      S_S6:  begin a0 = p6_q; b0 = W'(C_THIRTYSIXTH); end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q || issue;
    done0_d  = done0_q || fin0;
    done1_d  = done1_q || fin1;
    r0_d     = fin0 ? m0_res : r0_q;
    r1_d     = fin1 ? m1_res : r1_q;
    valid_d  = 1'b0;
    dt_d = dt_q; p2_d = p2_q; p3_d = p3_q; p4_d = p4_q; p5_d = p5_q; p6_d = p6_q;
    odt_d = odt_q; o2_d = o2_q; o3_d = o3_q; o4_d = o4_q; o5_d = o5_q; o6_d = o6_q;
    if (round_done) begin
      issued_d = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
    end
    case (state_q)
      S_IDLE: if (start && !valid_q) begin
        dt_d    = delta_t;
        state_d = S_P2;
      end
      S_P2:  if (round_done) begin p2_d = res0; state_d = S_P34; end
      S_P34: if (round_done) begin p3_d = res0; p4_d = res1; state_d = S_P56; end
      S_P56: if (round_done) begin p5_d = res0; p6_d = res1; state_d = S_S12; end
      S_S12: if (round_done) begin p2_d = res0; p3_d = res1; state_d = S_S34; end
      S_S34: if (round_done) begin p4_d = res0; p5_d = res1; state_d = S_S6; end
      S_S6:  if (round_done) begin p6_d = res0; state_d = S_DONE; end
      S_DONE: begin
        odt_d = dt_q; o2_d = p2_q; o3_d = p3_q; o4_d = p4_q; o5_d = p5_q; o6_d = p6_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      issued_q <= 1'b0; done0_q <= 1'b0; done1_q <= 1'b0; valid_q <= 1'b0;
      dt_q <= '0; r0_q <= '0; r1_q <= '0;
      p2_q <= '0; p3_q <= '0; p4_q <= '0; p5_q <= '0; p6_q <= '0;
      odt_q <= '0; o2_q <= '0; o3_q <= '0; o4_q <= '0; o5_q <= '0; o6_q <= '0;
    end else begin
      state_q <= state_d;
      issued_q <= issued_d; done0_q <= done0_d; done1_q <= done1_d; valid_q <= valid_d;
      dt_q <= dt_d; r0_q <= r0_d; r1_q <= r1_d;
      p2_q <= p2_d; p3_q <= p3_d; p4_q <= p4_d; p5_q <= p5_d; p6_q <= p6_d;
      odt_q <= odt_d; o2_q <= o2_d; o3_q <= o3_d; o4_q <= o4_d; o5_q <= o5_d; o6_q <= o6_d;
    end
  end

  // busy covers the valid_out cycle, so a start landing there is also ignored.
  assign busy          = (state_q != S_IDLE) || valid_q;
  assign valid_out     = valid_q;
  assign delta_t_out   = odt_q;
  assign dt2_half      = o2_q;
  assign dt3_sixth     = o3_q;
  assign dt4_twelth    = o4_q;
  assign dt5_twelth    = o5_q;
  assign dt6_thirtysix = o6_q;
endmodule
